// File: rtl/exe_1_pkg.sv
// Shared types for the exe_1 rising-edge detector.
package exe_1_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    EDGE = 2'd1,
    ONE  = 2'd2
  } edge_state_e;

  localparam edge_state_e RESET_STATE = ZERO;

endpackage

// File: rtl/exe_1.sv
// Rising-edge detector on in1 with Moore (out1), Mealy (out2) and
// registered-Mealy (out3) flags, showing the latency of each output style.
module exe_1
  import exe_1_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in1,
  output logic out1,
  output logic out2,
  output logic out3
);

  edge_state_e state;
  edge_state_e state_next;
  logic        mealy_term;

  always_comb begin
    state_next = RESET_STATE;
    case (state)
      ZERO:    state_next = in1 ? EDGE : ZERO;
      EDGE:    state_next = in1 ? ONE  : ZERO;
      ONE:     state_next = in1 ? ONE  : ZERO;
      // The spare encoding falls back to ZERO on the next clock.
      default: state_next = ZERO;
    endcase
  end

  always_comb begin
    mealy_term = (state == ZERO) && in1;
    out1       = (state == EDGE);
    // Gated by rst_ni so the combinational flag drops with the async reset.
    out2       = rst_ni && mealy_term;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= RESET_STATE;
      out3  <= 1'b0;
    end else begin
      state <= state_next;
      out3  <= mealy_term;
    end
  end

endmodule

// File: tb/tb_exe_1.sv
// Directed self-checking bench for exe_1: vector table plus reset sequences.
module tb_exe_1;

  logic clk_i;
  logic rst_ni;
  logic in1;
  logic out1;
  logic out2;
  logic out3;

  int unsigned checks;
  int unsigned errors;

  exe_1 dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .in1    (in1),
    .out1   (out1),
    .out2   (out2),
    .out3   (out3)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic in1;
    logic pre_out2;
    logic out1;
    logic out2;
    logic out3;
  } vec_t;

  localparam int unsigned NVEC = 12;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic e1, input logic e2, input logic e3);
    check({name, ".out1"}, out1, e1);
    check({name, ".out2"}, out2, e2);
    check({name, ".out3"}, out3, e3);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Expected values hand-derived from the transition table, starting in ZERO.
    //            in1   pre2  out1  out2  out3
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // idle
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1}; // ZERO->EDGE
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // EDGE->ONE
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // hold
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // hold
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // ONE->ZERO
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1}; // first pulse
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // EDGE->ZERO
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1}; // second pulse
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1}; // ends in EDGE

    // Reset held with in1 high: everything stays low across clocks.
    rst_ni = 1'b0;
    in1    = 1'b1;
    #1;
    check_all("reset_t0", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      check_all($sformatf("reset_clk%0d", i), 1'b0, 1'b0, 1'b0);
    end

    @(negedge clk_i);
    in1    = 1'b0;
    rst_ni = 1'b1;

    for (int unsigned i = 0; i < NVEC; i++) begin
      @(negedge clk_i);
      in1 = vecs[i].in1;
      #1;
      check($sformatf("vec%0d.pre_out2", i), out2, vecs[i].pre_out2);
      @(posedge clk_i);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].out1, vecs[i].out2, vecs[i].out3);
    end

    // Table ends in EDGE with in1 high; reset between edges clears everything at once.
    #2;
    rst_ni = 1'b0;
    #1;
    check_all("async_rst_now", 1'b0, 1'b0, 1'b0);
    @(posedge clk_i);
    #1;
    check_all("async_rst_hold", 1'b0, 1'b0, 1'b0);

    // Release with in1 still high: a fresh edge is reported.
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check_all("release_pre", 1'b0, 1'b1, 1'b0);
    @(posedge clk_i);
    #1;
    check_all("release_edge", 1'b1, 1'b0, 1'b1);
    @(posedge clk_i);
    #1;
    check_all("release_one", 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
